updown_count_ctrl: RTL



---
 rtl/updown_ctrl_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/updown_count_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/updown_ctrl_pkg.sv
// Shared state encoding, direction constants and BCD helper for the up/down run controller.
// Pure declarations: no latency, no flow control.
package updown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A digit pair holding a non-BCD code never matches, so it never reads as terminal.
  function automatic logic bcd_is_value(input logic [3:0] tens,
                                        input logic [3:0] units,
                                        input logic [6:0] value);
    logic [6:0] w_bin;
    w_bin = 7'(tens) * 7'd10 + 7'(units);
    return (tens <= 4'd9) && (units <= 4'd9) && (w_bin == value);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus rising-edge detector; a rise acts SYNC_STAGES edges after first sample.
// One pulse per press; a level already high when reset releases never produces a pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clc,
  input  logic i_raw,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SYNC_STAGES:0]   r_vld;

  // r_vld marks which chain positions (and r_prev) hold real post-reset samples.
  always_ff @(posedge clk) begin
    if (clc) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev & r_vld[SYNC_STAGES];

endmodule

// File: rtl/updown_count_ctrl.sv
// Run-control sequencer for the 2-digit BCD up/down counter; steps every TICK_DIV cycles, outputs registered.
// No backpressure; optional ping-pong at the terminal value when UPDOWN_AUTO_REVERSE_EN is defined.
module updown_count_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int MAX_COUNT   = 99,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clc,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_hold,
  input  logic       btn_clr,
  input  logic [3:0] cnt_units,
  input  logic [3:0] cnt_tens,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic [1:0] state_o,
  output logic       at_limit
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]     MAX_VAL    = 7'(MAX_COUNT);

  logic w_up_rise, w_down_rise, w_hold_rise, w_clr_rise;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clk(clk), .clc(clc), .i_raw(btn_up),   .o_rise(w_up_rise));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_down (
    .clk(clk), .clc(clc), .i_raw(btn_down), .o_rise(w_down_rise));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hold (
    .clk(clk), .clc(clc), .i_raw(btn_hold), .o_rise(w_hold_rise));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .clc(clc), .i_raw(btn_clr),  .o_rise(w_clr_rise));

  state_t        r_state;
  logic          r_dir;
  logic          r_saved_dir;
  logic          r_cnt_en;
  logic          r_cnt_clr;
  logic          r_at_limit;
  logic [PW-1:0] r_presc;

  logic w_ev_hold, w_ev_down, w_ev_up;
  logic w_go_up, w_go_down;
  logic w_run, w_tick, w_at_term;

  // Hold in IDLE is not an event at all, so it does not mask a coincident down/up.
  assign w_ev_hold = ~w_clr_rise & w_hold_rise & (r_state != ST_IDLE);
  assign w_ev_down = ~w_clr_rise & ~w_ev_hold & w_down_rise;
  assign w_ev_up   = ~w_clr_rise & ~w_ev_hold & ~w_down_rise & w_up_rise;

  // Re-pressing the running direction keeps the prescaler phase.
  assign w_go_down = w_ev_down & (r_state != ST_DOWN);
  assign w_go_up   = w_ev_up   & (r_state != ST_UP);

  assign w_run     = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_tick    = w_run && (r_presc == PRESC_LAST);
  assign w_at_term = (r_state == ST_UP) ? bcd_is_value(cnt_tens, cnt_units, MAX_VAL)
                                        : bcd_is_value(cnt_tens, cnt_units, 7'd0);

  always_ff @(posedge clk) begin
    if (clc) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_UP;
      r_saved_dir <= DIR_UP;
      r_cnt_en    <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_at_limit  <= 1'b0;
      r_presc     <= '0;
    end else begin
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
`ifdef UPDOWN_AUTO_REVERSE_EN
      r_at_limit <= 1'b0;
`endif
      if (w_clr_rise) begin
        r_state    <= ST_IDLE;
        r_cnt_clr  <= 1'b1;
        r_at_limit <= 1'b0;
        r_presc    <= '0;
      end else if (w_ev_hold) begin
        r_presc <= '0;
        if (r_state == ST_HOLD) begin
          r_state <= r_saved_dir ? ST_UP : ST_DOWN;
          r_dir   <= r_saved_dir;
        end else begin
          r_state     <= ST_HOLD;
          r_saved_dir <= r_dir;
        end
      end else if (w_go_down || w_go_up) begin
        r_state    <= w_go_up ? ST_UP : ST_DOWN;
        r_dir      <= w_go_up ? DIR_UP : DIR_DOWN;
        r_at_limit <= 1'b0;
        r_presc    <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        if (w_at_term) begin
          r_at_limit <= 1'b1;
`ifdef UPDOWN_AUTO_REVERSE_EN
          r_state <= (r_state == ST_UP) ? ST_DOWN : ST_UP;
          r_dir   <= (r_state == ST_UP) ? DIR_DOWN : DIR_UP;
`else
          r_state     <= ST_HOLD;
          r_saved_dir <= r_dir;
`endif
        end else begin
          r_cnt_en <= 1'b1;
        end
      end else if (w_run) begin
        r_presc <= r_presc + 1'b1;
      end else begin
        r_presc <= '0;
      end
    end
  end

  assign cnt_en   = r_cnt_en;
  assign cnt_dir  = r_dir;
  assign cnt_clr  = r_cnt_clr;
  assign state_o  = r_state;
  assign at_limit = r_at_limit;

endmodule
